mem_responder: RTL and testbench

- Memory-side responder for the CPU's two initiator ports: instruction fetch (ifu) and load/store (lsu).
- Holds a word-addressed 32-bit backing array.
- Each port has its own handshake FSM and latency counter, so a fetch and a load/store can be in flight at the same time.
- Used as the simulation and FPGA memory model behind the CPU top level.

---
 rtl/mem_responder.sv | 216 +++++++++++++++++++++
 tb/tb_mem_responder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory responder for the CPU fetch (ifu) and load/store (lsu) ports, each with its own FSM and latency counter.
// Define MEM_RAND_DELAY_EN to add 0..7 LFSR-chosen extra wait cycles per accepted request.
module mem_responder #(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_reqValid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_respValid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_reqValid,
    input  logic [31:0] lsu_addr,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_respValid,
    output logic [31:0] lsu_rdata,
    output logic        err
);
    localparam int          AW     = $clog2(MEM_WORDS);
    localparam logic [31:0] DEPTH  = 32'(MEM_WORDS);
    localparam logic [4:0]  LAT_M1 = 5'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    logic [31:0] mem_q [MEM_WORDS];

    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> 2) < DEPTH);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic misaligned(input logic [31:0] a, input logic [1:0] size);
        return (size == 2'd3) || (size == 2'd1 && a[0]) || (size == 2'd2 && a[1:0] != 2'b00);
    endfunction

    // Fetch port
    state_e      ifu_state_q;
    logic [4:0]  ifu_cnt_q;
    logic [31:0] ifu_addr_q;
    logic        ifu_resp_valid_q;
    logic [31:0] ifu_rdata_q;
    logic [4:0]  ifu_cnt_init;
    logic        ifu_accept, ifu_commit, ifu_ok;
    logic [31:0] ifu_addr_sel;

    // Load/store port
    state_e      lsu_state_q;
    logic [4:0]  lsu_cnt_q;
    logic [31:0] lsu_addr_q;
    logic [1:0]  lsu_size_q;
    logic        lsu_wen_q;
    logic [31:0] lsu_wdata_q;
    logic [3:0]  lsu_wmask_q;
    logic        lsu_resp_valid_q;
    logic [31:0] lsu_rdata_q;
    logic [4:0]  lsu_cnt_init;
    logic        lsu_accept, lsu_commit, lsu_ok, lsu_bad;
    logic [31:0] lsu_addr_sel;
    logic [1:0]  lsu_size_sel;
    logic        lsu_wen_sel;
    logic [31:0] lsu_wdata_sel;
    logic [3:0]  lsu_wmask_sel;

    logic        err_q;

`ifdef MEM_RAND_DELAY_EN
    logic [7:0] ifu_lfsr_q, lsu_lfsr_q;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    assign ifu_cnt_init = LAT_M1 + {2'b00, ifu_lfsr_q[2:0]};
    assign lsu_cnt_init = LAT_M1 + {2'b00, lsu_lfsr_q[2:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ifu_lfsr_q <= 8'hA5;
            lsu_lfsr_q <= 8'h5A;
        end else begin
            if (ifu_accept) ifu_lfsr_q <= lfsr_step(ifu_lfsr_q);
            if (lsu_accept) lsu_lfsr_q <= lfsr_step(lsu_lfsr_q);
        end
    end
`else
    assign ifu_cnt_init = LAT_M1;
    assign lsu_cnt_init = LAT_M1;
`endif

    // With a one-cycle latency the array is accessed on the accept edge, so the live request is used.
    assign ifu_accept   = (ifu_state_q == IDLE) && ifu_reqValid;
    assign ifu_addr_sel = (ifu_state_q == IDLE) ? ifu_addr : ifu_addr_q;
    assign ifu_commit   = (ifu_accept && ifu_cnt_init == 5'd0) ||
                          (ifu_state_q == WAIT && ifu_cnt_q == 5'd1);
    assign ifu_ok       = in_range(ifu_addr_sel);

    assign lsu_accept    = (lsu_state_q == IDLE) && lsu_reqValid;
    assign lsu_addr_sel  = (lsu_state_q == IDLE) ? lsu_addr  : lsu_addr_q;
    assign lsu_size_sel  = (lsu_state_q == IDLE) ? lsu_size  : lsu_size_q;
    assign lsu_wen_sel   = (lsu_state_q == IDLE) ? lsu_wen   : lsu_wen_q;
    assign lsu_wdata_sel = (lsu_state_q == IDLE) ? lsu_wdata : lsu_wdata_q;
    assign lsu_wmask_sel = (lsu_state_q == IDLE) ? lsu_wmask : lsu_wmask_q;
    assign lsu_commit    = (lsu_accept && lsu_cnt_init == 5'd0) ||
                           (lsu_state_q == WAIT && lsu_cnt_q == 5'd1);
    assign lsu_ok        = in_range(lsu_addr_sel);
    assign lsu_bad       = !lsu_ok || misaligned(lsu_addr_sel, lsu_size_sel);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ifu_state_q      <= IDLE;
            ifu_cnt_q        <= '0;
            ifu_addr_q       <= '0;
            ifu_resp_valid_q <= 1'b0;
            ifu_rdata_q      <= '0;
        end else begin
            ifu_resp_valid_q <= 1'b0;
            if (ifu_commit)
                ifu_rdata_q <= ifu_ok ? mem_q[word_idx(ifu_addr_sel)] : 32'h0;
            case (ifu_state_q)
                IDLE: if (ifu_reqValid) begin
                    ifu_addr_q <= ifu_addr;
                    ifu_cnt_q  <= ifu_cnt_init;
                    if (ifu_cnt_init == 5'd0) begin
                        ifu_state_q      <= RESP;
                        ifu_resp_valid_q <= 1'b1;
                    end else begin
                        ifu_state_q <= WAIT;
                    end
                end
                WAIT: begin
                    ifu_cnt_q <= ifu_cnt_q - 5'd1;
                    if (ifu_cnt_q == 5'd1) begin
                        ifu_state_q      <= RESP;
                        ifu_resp_valid_q <= 1'b1;
                    end
                end
                default: ifu_state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lsu_state_q      <= IDLE;
            lsu_cnt_q        <= '0;
            lsu_addr_q       <= '0;
            lsu_size_q       <= '0;
            lsu_wen_q        <= 1'b0;
            lsu_wdata_q      <= '0;
            lsu_wmask_q      <= '0;
            lsu_resp_valid_q <= 1'b0;
            lsu_rdata_q      <= '0;
        end else begin
            lsu_resp_valid_q <= 1'b0;
            if (lsu_commit)
                lsu_rdata_q <= lsu_ok ? mem_q[word_idx(lsu_addr_sel)] : 32'h0;
            case (lsu_state_q)
                IDLE: if (lsu_reqValid) begin
                    lsu_addr_q  <= lsu_addr;
                    lsu_size_q  <= lsu_size;
                    lsu_wen_q   <= lsu_wen;
                    lsu_wdata_q <= lsu_wdata;
                    lsu_wmask_q <= lsu_wmask;
                    lsu_cnt_q   <= lsu_cnt_init;
                    if (lsu_cnt_init == 5'd0) begin
                        lsu_state_q      <= RESP;
                        lsu_resp_valid_q <= 1'b1;
                    end else begin
                        lsu_state_q <= WAIT;
                    end
                end
                WAIT: begin
                    lsu_cnt_q <= lsu_cnt_q - 5'd1;
                    if (lsu_cnt_q == 5'd1) begin
                        lsu_state_q      <= RESP;
                        lsu_resp_valid_q <= 1'b1;
                    end
                end
                default: lsu_state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the backing array has no reset; the non-blocking write here is what gives
    // same-edge readers above the old word.
    always_ff @(posedge clock) begin
        if (lsu_commit && lsu_wen_sel && !lsu_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (lsu_wmask_sel[i])
                    mem_q[word_idx(lsu_addr_sel)][8*i +: 8] <= lsu_wdata_sel[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else if ((ifu_commit && !ifu_ok) || (lsu_commit && lsu_bad))
            err_q <= 1'b1;
    end

    assign ifu_respValid = ifu_resp_valid_q;
    assign ifu_rdata     = ifu_rdata_q;
    assign lsu_respValid = lsu_resp_valid_q;
    assign lsu_rdata     = lsu_rdata_q;
    assign err           = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, hand-written corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_responder;
    localparam int          LAT   = 2;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 4096;
    localparam int          NRAND = 400;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_reqValid, ifu_respValid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_reqValid, lsu_wen, lsu_respValid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [1:0]  lsu_size;
    logic [3:0]  lsu_wmask;
    logic        err;

    always #5 clock = ~clock;

    mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
        .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
        .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata), .err(err)
    );

    typedef struct {
        string       name;
        logic        ifu;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t st(string n, logic [31:0] a, logic [1:0] sz, logic [31:0] wd,
                                logic [3:0] wm, logic e);
        vec_t v;
        v.name = n; v.ifu = 1'b0; v.addr = a; v.size = sz; v.wen = 1'b1; v.wdata = wd;
        v.wmask = wm; v.chk_rd = 1'b0; v.exp_rd = '0; v.exp_err = e;
        return v;
    endfunction

    function automatic vec_t ld(string n, logic [31:0] a, logic [1:0] sz, logic [31:0] exp, logic e);
        vec_t v;
        v.name = n; v.ifu = 1'b0; v.addr = a; v.size = sz; v.wen = 1'b0; v.wdata = '0;
        v.wmask = '0; v.chk_rd = 1'b1; v.exp_rd = exp; v.exp_err = e;
        return v;
    endfunction

    function automatic vec_t fe(string n, logic [31:0] a, logic [31:0] exp, logic e);
        vec_t v;
        v.name = n; v.ifu = 1'b1; v.addr = a; v.size = 2'd2; v.wen = 1'b0; v.wdata = '0;
        v.wmask = '0; v.chk_rd = 1'b1; v.exp_rd = exp; v.exp_err = e;
        return v;
    endfunction

    // One request pulse, then wait (bounded) for its response and check latency, data and err.
    task automatic do_txn(input vec_t v);
        logic        got, err_s;
        int          lat;
        logic [31:0] rd;
        got = 1'b0; err_s = 1'b0; lat = 0; rd = '0;
        if (v.ifu) begin
            ifu_addr = v.addr; ifu_reqValid = 1'b1;
        end else begin
            lsu_addr = v.addr; lsu_size = v.size; lsu_wen = v.wen;
            lsu_wdata = v.wdata; lsu_wmask = v.wmask; lsu_reqValid = 1'b1;
        end
        for (int k = 1; k <= 8; k++) begin
            if (!got) begin
                next_cycle();
                ifu_reqValid = 1'b0;
                lsu_reqValid = 1'b0;
                @(negedge clock);
                if (v.ifu ? ifu_respValid : lsu_respValid) begin
                    got = 1'b1; lat = k; err_s = err;
                    rd = v.ifu ? ifu_rdata : lsu_rdata;
                end
            end
        end
        check({v.name, "_latency"}, 32'(lat), 32'(LAT));
        if (v.chk_rd) check({v.name, "_rdata"}, rd, v.exp_rd);
        check({v.name, "_err"}, 32'(err_s), 32'(v.exp_err));
        next_cycle();
    endtask

    // Reference model: byte-address view of the memory window used by the random phase.
    logic [31:0] mem_m [16];

    function automatic logic addr_ok(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'(WORDS * 4));
    endfunction

    function automatic logic bad_align(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!addr_ok(a)) return 32'h0;
        return mem_m[model_idx(a)];
    endfunction

    function automatic logic [31:0] rand_addr(input logic is_ifu);
        int r;
        r = $urandom_range(0, 19);
        if (r < 16) return BASE + 32'(r * 4) + (is_ifu ? 32'd0 : 32'($urandom_range(0, 3)));
        if (r == 16) return BASE - 32'd4;
        if (r == 17) return BASE + 32'(WORDS * 4);
        if (r == 18) return 32'h0000_0100;
        return 32'hFFFF_FFFC;
    endfunction

    vec_t        tbl[$];
    logic [9:0]  held_mask;
    logic        seen;
    int          ifu_free, lsu_free, ifu_due, lsu_due;
    logic        ifu_now, lsu_now, err_m;
    logic [31:0] ifu_a_m, lsu_a_m, lsu_wd_m, exp_ifu, exp_lsu, wv;
    logic [1:0]  lsu_sz_m;
    logic        lsu_we_m;
    logic [3:0]  lsu_wm_m;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl.push_back(st("st_w0",        32'h8000_0000, 2'd2, 32'h0010_0093, 4'hF,    1'b0));
        tbl.push_back(fe("fe_w0",        32'h8000_0000, 32'h0010_0093,                1'b0));
        tbl.push_back(st("st_w4_init",   32'h8000_0010, 2'd2, 32'h1122_3344, 4'hF,    1'b0));
        tbl.push_back(st("st_w4_mask",   32'h8000_0010, 2'd2, 32'hAABB_CCDD, 4'b0110, 1'b0));
        tbl.push_back(ld("ld_w4",        32'h8000_0010, 2'd2, 32'h11BB_CC44,          1'b0));
        tbl.push_back(ld("ld_w4_half",   32'h8000_0012, 2'd1, 32'h11BB_CC44,          1'b0));
        tbl.push_back(ld("ld_w4_byte",   32'h8000_0013, 2'd0, 32'h11BB_CC44,          1'b0));
        tbl.push_back(st("st_w4_byte3",  32'h8000_0013, 2'd0, 32'h9900_0000, 4'b1000, 1'b0));
        tbl.push_back(fe("fe_w4",        32'h8000_0010, 32'h99BB_CC44,                1'b0));
        tbl.push_back(st("st_last",      32'h8000_3FFC, 2'd2, 32'hCAFE_F00D, 4'hF,    1'b0));
        tbl.push_back(fe("fe_last",      32'h8000_3FFC, 32'hCAFE_F00D,                1'b0));
        tbl.push_back(st("st_w8",        32'h8000_0020, 2'd2, 32'h0123_4567, 4'hF,    1'b0));
        tbl.push_back(ld("ld_w8",        32'h8000_0020, 2'd2, 32'h0123_4567,          1'b0));
        tbl.push_back(ld("ld_below",     32'h7FFF_FFFC, 2'd2, 32'h0,                  1'b1));
        tbl.push_back(st("st_mis_half",  32'h8000_0001, 2'd1, 32'hFFFF_FFFF, 4'b0011, 1'b1));
        tbl.push_back(ld("ld_w0_kept",   32'h8000_0000, 2'd2, 32'h0010_0093,          1'b1));
        tbl.push_back(fe("fe_above",     32'h8000_4000, 32'h0,                        1'b1));
        tbl.push_back(st("st_size3",     32'h8000_0010, 2'd3, 32'h0000_0000, 4'hF,    1'b1));
        tbl.push_back(ld("ld_w4_byte1",  32'h8000_0011, 2'd0, 32'h99BB_CC44,          1'b1));
        tbl.push_back(ld("ld_w4_miswd",  32'h8000_0012, 2'd2, 32'h99BB_CC44,          1'b1));

        reset = 1'b1;
        ifu_reqValid = 1'b0; ifu_addr = '0;
        lsu_reqValid = 1'b0; lsu_addr = '0; lsu_size = '0; lsu_wen = 1'b0;
        lsu_wdata = '0; lsu_wmask = '0;
        @(posedge clock);
        @(negedge clock);
        check("rst_ifu_valid", 32'(ifu_respValid), 32'd0);
        check("rst_lsu_valid", 32'(lsu_respValid), 32'd0);
        check("rst_ifu_rdata", ifu_rdata, 32'h0);
        check("rst_lsu_rdata", lsu_rdata, 32'h0);
        check("rst_err",       32'(err), 32'd0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        foreach (tbl[i]) do_txn(tbl[i]);

        // Level-held fetch: accepted again in each IDLE cycle, responses at t+2, t+5, t+8.
        held_mask = '0;
        ifu_addr = BASE; ifu_reqValid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            held_mask[k] = ifu_respValid;
            if (k == 5) check("held_rdata", ifu_rdata, 32'h0010_0093);
            next_cycle();
        end
        ifu_reqValid = 1'b0;
        check("held_resp_pattern", 32'(held_mask), 32'h124);
        repeat (4) next_cycle();

        // Same-edge collision: fetch sees the old word, the store still lands.
        ifu_addr = BASE + 32'h10; ifu_reqValid = 1'b1;
        lsu_addr = BASE + 32'h10; lsu_size = 2'd2; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF; lsu_reqValid = 1'b1;
        next_cycle();
        ifu_reqValid = 1'b0; lsu_reqValid = 1'b0;
        @(negedge clock);
        check("coll_early", 32'({ifu_respValid, lsu_respValid}), 32'd0);
        next_cycle();
        @(negedge clock);
        check("coll_both_valid", 32'({ifu_respValid, lsu_respValid}), 32'd3);
        check("coll_ifu_old", ifu_rdata, 32'h99BB_CC44);
        next_cycle();
        do_txn(fe("coll_fe_new", BASE + 32'h10, 32'hDEAD_BEEF, 1'b1));

        // Reset one cycle after a store request: no response, store never commits.
        lsu_addr = BASE + 32'h20; lsu_size = 2'd2; lsu_wen = 1'b1;
        lsu_wdata = 32'hFFFF_FFFF; lsu_wmask = 4'hF; lsu_reqValid = 1'b1;
        next_cycle();
        lsu_reqValid = 1'b0;
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (lsu_respValid) seen = 1'b1;
            next_cycle();
            if (k == 1) reset = 1'b0;
        end
        check("rstmid_no_resp", 32'(seen), 32'd0);
        check("rstmid_err_clr", 32'(err), 32'd0);
        check("rstmid_rdata",   lsu_rdata, 32'h0);
        do_txn(ld("rstmid_ld_kept", BASE + 32'h20, 2'd2, 32'h0123_4567, 1'b0));

        // Random phase over words 0..15 plus out-of-range addresses.
        for (int i = 0; i < 16; i++) begin
            wv = $urandom;
            mem_m[i] = wv;
            do_txn(st("rnd_init", BASE + 32'(i * 4), 2'd2, wv, 4'hF, 1'b0));
        end
        err_m = 1'b0;
        ifu_free = 0; lsu_free = 0; ifu_due = -1; lsu_due = -1;
        ifu_a_m = '0; lsu_a_m = '0; lsu_wd_m = '0; lsu_sz_m = '0; lsu_we_m = 1'b0; lsu_wm_m = '0;
        exp_ifu = '0; exp_lsu = '0;
        for (int cyc = 0; cyc < NRAND + 20; cyc++) begin
            ifu_reqValid = (cyc < NRAND) && ($urandom_range(0, 1) == 1);
            ifu_addr     = rand_addr(1'b1);
            lsu_reqValid = (cyc < NRAND) && ($urandom_range(0, 1) == 1);
            lsu_addr     = rand_addr(1'b0);
            lsu_size     = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            lsu_wen      = ($urandom_range(0, 1) == 1);
            lsu_wdata    = $urandom;
            lsu_wmask    = 4'($urandom_range(0, 15));

            // Responses due this cycle: fetch reads before the store of the same edge applies.
            ifu_now = (ifu_due == cyc);
            lsu_now = (lsu_due == cyc);
            if (ifu_now) begin
                exp_ifu = model_read(ifu_a_m);
                if (!addr_ok(ifu_a_m)) err_m = 1'b1;
            end
            if (lsu_now) begin
                exp_lsu = model_read(lsu_a_m);
                if (!addr_ok(lsu_a_m) || bad_align(lsu_a_m, lsu_sz_m)) begin
                    err_m = 1'b1;
                end else if (lsu_we_m) begin
                    for (int b = 0; b < 4; b++)
                        if (lsu_wm_m[b]) mem_m[model_idx(lsu_a_m)][8*b +: 8] = lsu_wd_m[8*b +: 8];
                end
            end

            if (ifu_reqValid && cyc >= ifu_free) begin
                ifu_a_m = ifu_addr; ifu_due = cyc + LAT; ifu_free = cyc + LAT + 1;
            end
            if (lsu_reqValid && cyc >= lsu_free) begin
                lsu_a_m = lsu_addr; lsu_sz_m = lsu_size; lsu_we_m = lsu_wen;
                lsu_wd_m = lsu_wdata; lsu_wm_m = lsu_wmask;
                lsu_due = cyc + LAT; lsu_free = cyc + LAT + 1;
            end

            @(negedge clock);
            check($sformatf("rnd_ifu_valid@%0d", cyc), 32'(ifu_respValid), 32'(ifu_now));
            check($sformatf("rnd_lsu_valid@%0d", cyc), 32'(lsu_respValid), 32'(lsu_now));
            if (ifu_now) check($sformatf("rnd_ifu_rdata@%0d", cyc), ifu_rdata, exp_ifu);
            if (lsu_now && !lsu_we_m) check($sformatf("rnd_lsu_rdata@%0d", cyc), lsu_rdata, exp_lsu);
            check($sformatf("rnd_err@%0d", cyc), 32'(err), 32'(err_m));
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
